// File: rtl/mul_seq_shift_add.sv
// Sequential shift-and-add multiplier with a start/done handshake.
// Takes WIDTH cycles per product using a single WIDTH-bit adder.
// Optional signed (two's-complement) mode is compiled in when the macro
// MUL_SEQ_SIGNED_EN is defined; otherwise signed_mode is ignored and all
// products are unsigned. The port list is the same in both builds.
module mul_seq_shift_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_p;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_result;
  logic                 w_last;

`ifdef MUL_SEQ_SIGNED_EN
  logic                 r_neg;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic                 w_res_neg;

  // Magnitudes of the operands; the most negative value maps onto
  // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit value.
  assign w_neg_a   = signed_mode & a[WIDTH-1];
  assign w_neg_b   = signed_mode & b[WIDTH-1];
  assign w_mag_a   = w_neg_a ? (~a + WIDTH'(1)) : a;
  assign w_mag_b   = w_neg_b ? (~b + WIDTH'(1)) : b;
  assign w_res_neg = w_neg_a ^ w_neg_b;
  assign w_result  = r_neg ? (~w_acc_next + (2*WIDTH)'(1)) : w_acc_next;
`else
  logic                 w_unused_signed_mode;

  assign w_unused_signed_mode = signed_mode;
  assign w_mag_a  = a;
  assign w_mag_b  = b;
  assign w_result = w_acc_next;
`endif

  // One iteration: conditionally add the multiplicand into the upper half,
  // keeping the carry, then shift {carry, accumulator} right by one.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = start ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        busy   = 1'b1;
        w_next = w_last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = start ? S_RUN : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture on accept, iterate in RUN, load product on
  // the final iteration edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
`ifdef MUL_SEQ_SIGNED_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            r_neg    <= w_res_neg;
`endif
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_p <= w_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// Directed self-checking bench for mul_seq_shift_add (WIDTH=8 instance plus
// a WIDTH=4 instance swept over all operand pairs in both modes).
module tb_mul_seq_shift_add;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  logic        start4;
  logic        signed_mode4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  p4;

  int checks   = 0;
  int failures = 0;

  mul_seq_shift_add #(.WIDTH(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .p           (p)
  );

  mul_seq_shift_add #(.WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start4),
    .signed_mode (signed_mode4),
    .a           (a4),
    .b           (b4),
    .busy        (busy4),
    .done        (done4),
    .p           (p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for done on the WIDTH=8 instance, bounded; returns ticks taken.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Issue one multiply with a single-cycle start pulse and check the full
  // busy window, the done pulse, and the product.
  task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                     input logic sm, input logic [15:0] exp);
    a = ia; b = ib; signed_mode = sm; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, {30'd0, busy, done}, 32'b10);
      tick();
    end
    chk({tag, "_done"}, {30'd0, busy, done}, 32'b01);
    chk({tag, "_p"}, {16'd0, p}, {16'd0, exp});
  endtask

  logic [7:0]  pa [3];
  logic [7:0]  pb [3];
  logic [15:0] pe [3];

  initial begin
    int n;
    int sa;
    int sb;
    logic [7:0] e4;

    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    start4 = 1'b0; signed_mode4 = 1'b0; a4 = '0; b4 = '0;
    tick();
    tick();
    chk("reset_outs", {14'd0, busy, done, p}, 32'd0);
    chk("reset_outs4", {22'd0, busy4, done4, p4}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Unsigned full-scale product; p held afterwards.
    op8("ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    tick();
    chk("ff_ff_after", {14'd0, busy, done, p}, {16'd0, 2'b00, 14'd0} | 32'h0000FE01);

    // Signed-mode vectors; without the macro they are plain unsigned.
`ifdef MUL_SEQ_SIGNED_EN
    op8("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
    op8("s_fd_05", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
    op8("s_05_fd", 8'h05, 8'hFD, 1'b1, 16'hFFF1);
    op8("s_fd_fd", 8'hFD, 8'hFD, 1'b1, 16'h0009);
    op8("s_7f_80", 8'h7F, 8'h80, 1'b1, 16'hC080);
`else
    op8("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
    op8("s_fd_05", 8'hFD, 8'h05, 1'b1, 16'h04F1);
    op8("s_05_fd", 8'h05, 8'hFD, 1'b1, 16'h04F1);
    op8("s_fd_fd", 8'hFD, 8'hFD, 1'b1, 16'hFA09);
    op8("s_7f_80", 8'h7F, 8'h80, 1'b1, 16'h3F80);
`endif
    op8("u_fd_05", 8'hFD, 8'h05, 1'b0, 16'h04F1);
    op8("zero_a", 8'h00, 8'hA5, 1'b0, 16'h0000);
    tick();

    // start pulsed during RUN is ignored.
    a = 8'd7; b = 8'd9; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'd1; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("ign_latency", n, 8);
    chk("ign_p", {16'd0, p}, 32'd63);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ign_no_second", {30'd0, busy, done}, 32'd0);
    end

    // Reset mid-RUN aborts with no done.
    a = 8'h33; b = 8'h44; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_outs", {14'd0, busy, done, p}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_no_done", {30'd0, busy, done}, 32'd0);
    end
    op8("after_rst", 8'd12, 8'd10, 1'b0, 16'd120);

    // Reset wins over start on the same edge.
    rst_n = 1'b0; a = 8'd5; b = 8'd5; start = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0;
    chk("rst_vs_start", {14'd0, busy, done, p}, 32'd0);
    tick();

    // start held high: back-to-back operations every WIDTH+1 cycles.
    pa[0] = 8'h12; pb[0] = 8'h34; pe[0] = 16'h03A8;
    pa[1] = 8'hFF; pb[1] = 8'h01; pe[1] = 16'h00FF;
    pa[2] = 8'h80; pb[2] = 8'h02; pe[2] = 16'h0100;
    signed_mode = 1'b0;
    a = pa[0]; b = pb[0]; start = 1'b1;
    tick();
    a = pa[1]; b = pb[1];
    wait_done(n);
    chk("held0_lat", n, 8);
    chk("held0_p", {16'd0, p}, {16'd0, pe[0]});
    for (int k = 1; k < 3; k++) begin
      tick();
      if (k < 2) begin
        a = pa[k+1]; b = pb[k+1];
      end else begin
        start = 1'b0;
      end
      chk("held_busy", {30'd0, busy, done}, 32'b10);
      wait_done(n);
      chk("held_spacing", n + 1, 9);
      chk("held_p", {16'd0, p}, {16'd0, pe[k]});
    end
    tick();
    chk("held_end", {30'd0, busy, done}, 32'd0);

    // WIDTH=4 sweep over every operand pair in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          a4 = 4'(i); b4 = 4'(j); signed_mode4 = (m == 1); start4 = 1'b1;
          tick();
          start4 = 1'b0;
          n = 0;
          while (done4 !== 1'b1 && n < 20) begin
            tick();
            n++;
          end
`ifdef MUL_SEQ_SIGNED_EN
          sa = (m == 1 && i >= 8) ? i - 16 : i;
          sb = (m == 1 && j >= 8) ? j - 16 : j;
`else
          sa = i;
          sb = j;
`endif
          e4 = 8'(sa * sb);
          chk("w4_lat", n, 4);
          chk("w4_p", {24'd0, p4}, {24'd0, e4});
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
